// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial bit source
// feeding the sequence detector.
package seq_pkg;

    localparam int WORD_WIDTH_DEF = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO with first-word fall-through read data
// and full/empty/count status.
module sync_fifo
    import seq_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH_DEF,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_wr      = i_wr_en & ~o_full;
    assign w_rd      = i_rd_en & ~o_empty;
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            if (w_wr && !w_rd)
                r_count <= r_count + 1'b1;
            else if (!w_wr && w_rd)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_wr_data;
    end

endmodule

// File: rtl/bit_serializer.sv
// Buffers parallel words and shifts them out one bit per enabled
// cycle, streaming back-to-back words without gap cycles.
module bit_serializer
    import seq_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1,
    localparam int PW = $clog2(FIFO_DEPTH + 2)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  enable,
    output logic                  seq,
    output logic                  valid,
    output logic [PW-1:0]         words_pending
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(WORD_WIDTH + 1);

    state_t                r_state;
    logic [WORD_WIDTH-1:0] r_shift;
    logic [BW-1:0]         r_cnt;
    logic                  r_armed;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_last;
    logic                  w_shift;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic [WORD_WIDTH-1:0] w_head;
    logic                  w_bit;

    sync_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_push),
        .i_wr_data (in_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    assign w_shift  = (r_state == ST_SHIFT);
    assign w_last   = (r_cnt == BW'(1));
    assign w_bit    = (MSB_FIRST != 0) ? r_shift[WORD_WIDTH-1]
                                       : r_shift[0];
    assign valid    = w_shift & enable;
    assign seq      = w_shift & w_bit;
    assign in_ready = r_armed & ~w_full;
    assign w_push   = in_valid & in_ready;
    assign w_pop    = ~w_empty & (~w_shift | (valid & w_last));

    assign words_pending = PW'(w_count) + PW'(w_shift);

    // r_armed keeps in_ready low until the first edge out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= ST_SHIFT;
                        r_shift <= w_head;
                        r_cnt   <= BW'(WORD_WIDTH);
                    end
                end
                ST_SHIFT: begin
                    if (valid && w_last && !w_empty) begin
                        r_shift <= w_head;
                        r_cnt   <= BW'(WORD_WIDTH);
                    end else if (valid && w_last) begin
                        r_state <= ST_IDLE;
                        r_shift <= '0;
                        r_cnt   <= '0;
                    end else if (valid) begin
                        r_shift <= (MSB_FIRST != 0)
                            ? {r_shift[WORD_WIDTH-2:0], 1'b0}
                            : {1'b0, r_shift[WORD_WIDTH-1:1]};
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
